// File: rtl/dmac_control_unit.sv
// dmac_control_unit
//   Control FSM for the two-channel AHB DMA controller. It arbitrates two
//   peripheral requests with a fixed priority (channel 1 first) and interrupts
//   the CPU so that it programs the transfer. It then requests the AHB bus,
//   runs the selected channel while the grant is held, and acknowledges the
//   peripheral once the datapath signals completion. A configuration watchdog
//   abandons requests that the CPU never services.
//
// Parameters
//   CFG_TIMEOUT  cycles allowed in WAIT_CFG before abort (0 disables watchdog)
//   CNT_W        watchdog counter width (CFG_TIMEOUT < 2**CNT_W)
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   DmacReq[1:0]  peripheral requests (bit0 = ch1, bit1 = ch2), level
//   C_config      CPU finished configuring (datapath Ctrl_Reg[16])
//   irq           transfer complete from datapath
//   con_new_sel   latched channel select from datapath
//   HGrant        AHB bus grant
//   HBusReq       AHB bus request
//   con_en        datapath select-latch enable
//   con_sel       channel select (0 = ch1, 1 = ch2)
//   channel_en_1  run channel 1
//   channel_en_2  run channel 2
//   cfg_req       CPU interrupt: configure DMAC
//   DmacAck[1:0]  one-cycle acknowledge to the served peripheral
//   cfg_err       one-cycle pulse on watchdog abort
module dmac_control_unit #(
    parameter int unsigned CFG_TIMEOUT = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] DmacReq,
    input  logic       C_config,
    input  logic       irq,
    input  logic       con_new_sel,
    input  logic       HGrant,
    output logic       HBusReq,
    output logic       con_en,
    output logic       con_sel,
    output logic       channel_en_1,
    output logic       channel_en_2,
    output logic       cfg_req,
    output logic [1:0] DmacAck,
    output logic       cfg_err
);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        WAIT_CFG,
        BUS_REQ,
        XFER,
        DONE
    } state_t;

    // Counter value seen in the last permitted WAIT_CFG cycle.
    localparam logic [CNT_W-1:0] CNT_LAST =
        (CFG_TIMEOUT == 0) ? '0 : CNT_W'(CFG_TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic             sel_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cfg_err_q;
    logic             wd_expire;

    // C_config wins over the timeout when both occur in the same cycle.
    assign wd_expire = (CFG_TIMEOUT != 0) && (state_q == WAIT_CFG) &&
                       !C_config && (cnt_q == CNT_LAST);

    // State register, channel select, watchdog counter, error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= wd_expire;
            // Channel 1 has priority: pick channel 2 only when bit0 is low.
            if (state_q == IDLE && DmacReq != 2'b00) begin
                sel_q <= ~DmacReq[0];
            end
            if (state_q == ARB) begin
                cnt_q <= '0;
            end else if (state_q == WAIT_CFG) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (DmacReq != 2'b00) state_d = ARB;
            end
            ARB: begin
                state_d = WAIT_CFG;
            end
            WAIT_CFG: begin
                if (C_config)       state_d = BUS_REQ;
                else if (wd_expire) state_d = IDLE;
            end
            BUS_REQ: begin
                if (HGrant) state_d = XFER;
            end
            XFER: begin
                if (irq) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: Moore decode of state/sel_q; channel enables also gate on HGrant.
    always_comb begin
        HBusReq      = 1'b0;
        con_en       = 1'b0;
        cfg_req      = 1'b0;
        DmacAck      = 2'b00;
        channel_en_1 = 1'b0;
        channel_en_2 = 1'b0;
        con_sel      = sel_q;
        cfg_err      = cfg_err_q;
        unique case (state_q)
            ARB:      con_en  = 1'b1;
            WAIT_CFG: cfg_req = 1'b1;
            BUS_REQ:  HBusReq = 1'b1;
            XFER: begin
                HBusReq      = 1'b1;
                channel_en_1 = HGrant & ~con_new_sel;
                channel_en_2 = HGrant &  con_new_sel;
            end
            DONE:     DmacAck = sel_q ? 2'b10 : 2'b01;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmac_control_unit.sv
// tb_dmac_control_unit
//   Scoreboard bench for dmac_control_unit. Each stimulus cycle pushes the
//   output vector the design must show in that cycle; a negedge monitor pops
//   and compares it. Vector layout:
//   {HBusReq, con_en, con_sel, channel_en_1, channel_en_2, cfg_req, DmacAck[1:0], cfg_err}
module tb_dmac_control_unit;

    logic       clk;
    logic       rst;
    logic [1:0] DmacReq;
    logic       C_config;
    logic       irq;
    logic       con_new_sel;
    logic       HGrant;
    logic       HBusReq;
    logic       con_en;
    logic       con_sel;
    logic       channel_en_1;
    logic       channel_en_2;
    logic       cfg_req;
    logic [1:0] DmacAck;
    logic       cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] exp_q[$];
    string      tag_q[$];
    logic [8:0] obs;

    localparam logic [8:0] Z = 9'b0;

    dmac_control_unit #(
        .CFG_TIMEOUT(8),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .DmacReq     (DmacReq),
        .C_config    (C_config),
        .irq         (irq),
        .con_new_sel (con_new_sel),
        .HGrant      (HGrant),
        .HBusReq     (HBusReq),
        .con_en      (con_en),
        .con_sel     (con_sel),
        .channel_en_1(channel_en_1),
        .channel_en_2(channel_en_2),
        .cfg_req     (cfg_req),
        .DmacAck     (DmacAck),
        .cfg_err     (cfg_err)
    );

    assign obs = {HBusReq, con_en, con_sel, channel_en_1, channel_en_2,
                  cfg_req, DmacAck, cfg_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ex(input logic hb, input logic ce, input logic cs,
                                      input logic e1, input logic e2, input logic cr,
                                      input logic [1:0] ack, input logic err);
        return {hb, ce, cs, e1, e2, cr, ack, err};
    endfunction

    // Scoreboard monitor: compare in the middle of each cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            check(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    end

    // Drive one cycle of inputs (called just after a rising edge) and queue
    // the outputs expected in that same cycle.
    task automatic st(input string tag, input logic [1:0] req, input logic cfg,
                      input logic irq_i, input logic grant, input logic nsel,
                      input logic [8:0] exp);
        DmacReq     = req;
        C_config    = cfg;
        irq         = irq_i;
        HGrant      = grant;
        con_new_sel = nsel;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input string tag);
        DmacReq     = 2'b00;
        C_config    = 1'b0;
        irq         = 1'b0;
        HGrant      = 1'b0;
        con_new_sel = 1'b0;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " in_reset"}, obs, Z);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        apply_reset("reset");

        // S1: single channel-1 transfer, minimum latency.
        st("s1 c0 idle", 2'b01, 1, 0, 1, 0, Z);
        st("s1 c1 arb",  2'b01, 1, 0, 1, 0, ex(0,1,0,0,0,0,2'b00,0));
        st("s1 c2 wcfg", 2'b01, 1, 0, 1, 0, ex(0,0,0,0,0,1,2'b00,0));
        st("s1 c3 breq", 2'b01, 1, 0, 1, 0, ex(1,0,0,0,0,0,2'b00,0));
        for (int i = 4; i < 10; i++)
            st($sformatf("s1 c%0d xfer", i), 2'b01, 1, 0, 1, 0, ex(1,0,0,1,0,0,2'b00,0));
        st("s1 c10 irq",  2'b01, 1, 1, 1, 0, ex(1,0,0,1,0,0,2'b00,0));
        st("s1 c11 done", 2'b01, 1, 0, 1, 0, ex(0,0,0,0,0,0,2'b01,0));
        st("s1 c12 idle", 2'b00, 1, 0, 1, 0, Z);
        st("s1 c13 idle", 2'b00, 1, 0, 1, 0, Z);
        apply_reset("s1");

        // S2: both requests; channel 1 first, then channel 2.
        st("s2 c0 idle",  2'b11, 1, 0, 1, 0, Z);
        st("s2 c1 arb",   2'b11, 1, 0, 1, 0, ex(0,1,0,0,0,0,2'b00,0));
        st("s2 c2 wcfg",  2'b11, 1, 0, 1, 0, ex(0,0,0,0,0,1,2'b00,0));
        st("s2 c3 breq",  2'b11, 1, 0, 1, 0, ex(1,0,0,0,0,0,2'b00,0));
        st("s2 c4 xfer",  2'b11, 1, 0, 1, 0, ex(1,0,0,1,0,0,2'b00,0));
        st("s2 c5 irq",   2'b11, 1, 1, 1, 0, ex(1,0,0,1,0,0,2'b00,0));
        st("s2 c6 done",  2'b11, 1, 0, 1, 0, ex(0,0,0,0,0,0,2'b01,0));
        st("s2 c7 idle",  2'b10, 1, 0, 1, 0, Z);
        st("s2 c8 arb",   2'b10, 1, 0, 1, 1, ex(0,1,1,0,0,0,2'b00,0));
        st("s2 c9 wcfg",  2'b10, 1, 0, 1, 1, ex(0,0,1,0,0,1,2'b00,0));
        st("s2 c10 breq", 2'b10, 1, 0, 1, 1, ex(1,0,1,0,0,0,2'b00,0));
        st("s2 c11 xfer", 2'b10, 1, 0, 1, 1, ex(1,0,1,0,1,0,2'b00,0));
        st("s2 c12 irq",  2'b10, 1, 1, 1, 1, ex(1,0,1,0,1,0,2'b00,0));
        st("s2 c13 done", 2'b10, 1, 0, 1, 1, ex(0,0,1,0,0,0,2'b10,0));
        st("s2 c14 idle", 2'b00, 1, 0, 1, 1, ex(0,0,1,0,0,0,2'b00,0));
        apply_reset("s2");

        // S3: grant withdrawn for 3 cycles mid-transfer.
        st("s3 c0 idle", 2'b01, 1, 0, 1, 0, Z);
        st("s3 c1 arb",  2'b01, 1, 0, 1, 0, ex(0,1,0,0,0,0,2'b00,0));
        st("s3 c2 wcfg", 2'b01, 1, 0, 1, 0, ex(0,0,0,0,0,1,2'b00,0));
        st("s3 c3 breq", 2'b01, 1, 0, 1, 0, ex(1,0,0,0,0,0,2'b00,0));
        st("s3 c4 xfer", 2'b01, 1, 0, 1, 0, ex(1,0,0,1,0,0,2'b00,0));
        for (int i = 5; i < 8; i++)
            st($sformatf("s3 c%0d nogrant", i), 2'b01, 1, 0, 0, 0, ex(1,0,0,0,0,0,2'b00,0));
        st("s3 c8 regrant", 2'b01, 1, 0, 1, 0, ex(1,0,0,1,0,0,2'b00,0));
        st("s3 c9 irq",     2'b01, 1, 1, 1, 0, ex(1,0,0,1,0,0,2'b00,0));
        st("s3 c10 done",   2'b01, 1, 0, 1, 0, ex(0,0,0,0,0,0,2'b01,0));
        st("s3 c11 idle",   2'b00, 1, 0, 1, 0, Z);
        apply_reset("s3");

        // S4: watchdog abort after 8 WAIT_CFG cycles; held request re-arbitrates.
        st("s4 c0 idle", 2'b01, 0, 0, 1, 0, Z);
        st("s4 c1 arb",  2'b01, 0, 0, 1, 0, ex(0,1,0,0,0,0,2'b00,0));
        for (int i = 2; i < 10; i++)
            st($sformatf("s4 c%0d wcfg", i), 2'b01, 0, 0, 1, 0, ex(0,0,0,0,0,1,2'b00,0));
        st("s4 c10 err",  2'b01, 0, 0, 1, 0, ex(0,0,0,0,0,0,2'b00,1));
        st("s4 c11 arb",  2'b01, 0, 0, 1, 0, ex(0,1,0,0,0,0,2'b00,0));
        apply_reset("s4");

        // S4b: C_config arrives in the last watchdog cycle and wins.
        st("s4b c0 idle", 2'b01, 0, 0, 1, 0, Z);
        st("s4b c1 arb",  2'b01, 0, 0, 1, 0, ex(0,1,0,0,0,0,2'b00,0));
        for (int i = 2; i < 9; i++)
            st($sformatf("s4b c%0d wcfg", i), 2'b01, 0, 0, 1, 0, ex(0,0,0,0,0,1,2'b00,0));
        st("s4b c9 cfg",   2'b01, 1, 0, 1, 0, ex(0,0,0,0,0,1,2'b00,0));
        st("s4b c10 breq", 2'b01, 1, 0, 1, 0, ex(1,0,0,0,0,0,2'b00,0));
        apply_reset("s4b");

        // S5: asynchronous reset during XFER, then restart of the held request.
        st("s5 c0 idle", 2'b01, 1, 0, 1, 0, Z);
        st("s5 c1 arb",  2'b01, 1, 0, 1, 0, ex(0,1,0,0,0,0,2'b00,0));
        st("s5 c2 wcfg", 2'b01, 1, 0, 1, 0, ex(0,0,0,0,0,1,2'b00,0));
        st("s5 c3 breq", 2'b01, 1, 0, 1, 0, ex(1,0,0,0,0,0,2'b00,0));
        st("s5 c4 xfer", 2'b01, 1, 0, 1, 0, ex(1,0,0,1,0,0,2'b00,0));
        #2;
        rst = 1'b1;
        #1;
        check("s5 async_rst", obs, Z);
        @(posedge clk);
        #1;
        check("s5 rst_held", obs, Z);
        rst = 1'b0;
        st("s5 r0 idle", 2'b01, 1, 0, 1, 0, Z);
        st("s5 r1 arb",  2'b01, 1, 0, 1, 0, ex(0,1,0,0,0,0,2'b00,0));
        apply_reset("s5");

        // S6: stray C_config in IDLE and stray irq in WAIT_CFG are ignored.
        st("s6 c0 idle_cfg", 2'b00, 1, 0, 1, 0, Z);
        st("s6 c1 idle",     2'b01, 0, 0, 1, 0, Z);
        st("s6 c2 arb",      2'b01, 0, 0, 1, 0, ex(0,1,0,0,0,0,2'b00,0));
        st("s6 c3 wcfg_irq", 2'b01, 0, 1, 1, 0, ex(0,0,0,0,0,1,2'b00,0));
        st("s6 c4 wcfg",     2'b01, 1, 0, 1, 0, ex(0,0,0,0,0,1,2'b00,0));
        st("s6 c5 breq",     2'b01, 1, 0, 1, 0, ex(1,0,0,0,0,0,2'b00,0));
        apply_reset("s6");

        check("sb_drained", 9'(exp_q.size()), Z);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
